// File: rtl/data_to_axi_packer.sv
// rtl/data_to_axi_packer.sv - packs one element per beat into NUM_ELEMENTS-slot AXI-Stream beats
// Partial beats flush on in_last_i; unused or keep-low slots carry tkeep = 0.
module data_to_axi_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int AXI_WIDTH    = 512,
  parameter int NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH,
  localparam int ELEM_BYTES  = DATA_WIDTH / 8,
  localparam int KEEP_W      = AXI_WIDTH / 8,
  localparam int CNT_W       = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_keep_i,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [AXI_WIDTH-1:0]  out_tdata_o,
  output logic [KEEP_W-1:0]     out_tkeep_o,
  output logic                  out_tlast_o,
  output logic                  out_tvalid_o,
  input  logic                  out_tready_i
);

  if (NUM_ELEMENTS < 2) begin : g_bad_num_elements
    $error("data_to_axi_packer: NUM_ELEMENTS must be >= 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("data_to_axi_packer: DATA_WIDTH must be a multiple of 8");
  end
  if ((AXI_WIDTH % DATA_WIDTH) != 0) begin : g_bad_axi_width
    $error("data_to_axi_packer: AXI_WIDTH must be a multiple of DATA_WIDTH");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [AXI_WIDTH-1:0]    acc_data_q, acc_data_d;
  logic [NUM_ELEMENTS-1:0] acc_keep_q, acc_keep_d;
  logic                    out_valid_q, out_valid_d;
  logic [AXI_WIDTH-1:0]    out_data_q, out_data_d;
  logic [KEEP_W-1:0]       out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;

  logic                    accept;
  logic                    closing;
  logic [AXI_WIDTH-1:0]    merged_data;
  logic [NUM_ELEMENTS-1:0] merged_keep;
  logic [KEEP_W-1:0]       merged_tkeep;

  assign in_ready_o = !out_valid_q || out_tready_i;

  always_comb begin
    accept       = in_valid_i && in_ready_o;
    closing      = (cnt_q == CNT_W'(NUM_ELEMENTS - 1)) || in_last_i;
    merged_data  = '0;
    merged_keep  = '0;
    merged_tkeep = '0;
    // Slots above cnt are forced to zero so a flushed partial beat never leaks stale data.
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (i < int'(cnt_q)) begin
        merged_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_data_q[i*DATA_WIDTH +: DATA_WIDTH];
        merged_keep[i]                          = acc_keep_q[i];
      end else if (i == int'(cnt_q)) begin
        merged_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
        merged_keep[i]                          = in_keep_i;
      end
      merged_tkeep[i*ELEM_BYTES +: ELEM_BYTES] = {ELEM_BYTES{merged_keep[i]}};
    end

    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (out_tready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (closing) begin
        cnt_d       = '0;
        acc_data_d  = '0;
        acc_keep_d  = '0;
        out_valid_d = 1'b1;
        out_data_d  = merged_data;
        out_keep_d  = merged_tkeep;
        out_last_d  = in_last_i;
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_tdata_o  = out_data_q;
  assign out_tkeep_o  = out_keep_q;
  assign out_tlast_o  = out_last_q;
  assign out_tvalid_o = out_valid_q;

endmodule

// File: tb/tb_data_to_axi_packer.sv
// tb/tb_data_to_axi_packer.sv - directed and randomized checks of data_to_axi_packer
// Expected beats come from a slot-list packing model; captured beats are compared in order.
module tb_data_to_axi_packer;

  localparam int DW = 32;
  localparam int AW = 128;
  localparam int NE = AW / DW;
  localparam int KW = AW / 8;

  typedef struct {
    logic [AW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_keep = 1'b0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;

  beat_t         exp_q[$];
  beat_t         got_q[$];
  logic [DW-1:0] slot_d[$];
  logic          slot_k[$];

  data_to_axi_packer #(.DATA_WIDTH(DW), .AXI_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_tdata_o(out_tdata), .out_tkeep_o(out_tkeep), .out_tlast_o(out_tlast),
    .out_tvalid_o(out_tvalid), .out_tready_i(out_tready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_tvalid && out_tready) got_q.push_back('{d: out_tdata, k: out_tkeep, l: out_tlast});
  end

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: elements collect into a slot list; a full list or a last element forms one beat.
  task automatic model_push(input logic [DW-1:0] d, input logic k, input logic l);
    beat_t b;
    slot_d.push_back(d);
    slot_k.push_back(k);
    if (slot_d.size() == NE || l) begin
      b.d = '0;
      b.k = '0;
      b.l = l;
      foreach (slot_d[i]) begin
        b.d[i*DW +: DW] = slot_d[i];
        if (slot_k[i]) b.k[i*(DW/8) +: DW/8] = '1;
      end
      exp_q.push_back(b);
      slot_d.delete();
      slot_k.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the element is accepted.
  task automatic send(input logic [DW-1:0] d, input logic k, input logic l, output int waits);
    bit done = 1'b0;
    waits = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    while (!done && waits < 200) begin
      if (rand_ready) out_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) waits++;
    end
    in_valid = 1'b0;
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL send_timeout observed=%0d expected=<200", waits);
    end
    if (done) model_push(d, k, l);
  endtask

  task automatic check_beats(input string tag);
    beat_t e, g;
    out_tready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, AW'(got_q.size()), AW'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_tdata"}, g.d, e.d);
      chk({tag, "_tkeep"}, AW'(g.k), AW'(e.k));
      chk({tag, "_tlast"}, AW'(g.l), AW'(e.l));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int w;
    int wsum;
    int len;
    logic [AW-1:0] held;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_tvalid", AW'(out_tvalid), '0);
    chk("reset_tdata", out_tdata, '0);
    chk("reset_tkeep", AW'(out_tkeep), '0);
    chk("reset_tlast", AW'(out_tlast), '0);
    chk("reset_in_ready", AW'(in_ready), AW'(1));

    wsum = 0;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), 1'b1, (i == 8), w);
      wsum += w;
    end
    chk("full_ready_stalls", AW'(wsum), '0);
    repeat (2) @(negedge clk);
    chk("full_b0_tdata", got_q.size() > 0 ? got_q[0].d : '0, 128'h00000004_00000003_00000002_00000001);
    chk("full_b0_tkeep", got_q.size() > 0 ? AW'(got_q[0].k) : '0, AW'(16'hFFFF));
    chk("full_b0_tlast", got_q.size() > 0 ? AW'(got_q[0].l) : AW'(1), '0);
    chk("full_b1_tdata", got_q.size() > 1 ? got_q[1].d : '0, 128'h00000008_00000007_00000006_00000005);
    chk("full_b1_tlast", got_q.size() > 1 ? AW'(got_q[1].l) : '0, AW'(1));
    @(posedge clk);
    #1;
    check_beats("full");

    send(32'hA, 1'b1, 1'b0, w);
    send(32'hB, 1'b1, 1'b1, w);
    repeat (2) @(negedge clk);
    chk("partial_tkeep", got_q.size() > 0 ? AW'(got_q[0].k) : '0, AW'(16'h00FF));
    @(posedge clk);
    #1;
    check_beats("partial");

    send(32'hC0, 1'b1, 1'b0, w);
    send(32'hC1, 1'b0, 1'b0, w);
    send(32'hC2, 1'b1, 1'b0, w);
    send(32'hC3, 1'b1, 1'b1, w);
    repeat (2) @(negedge clk);
    chk("gaps_tkeep", got_q.size() > 0 ? AW'(got_q[0].k) : '0, AW'(16'hFF0F));
    chk("gaps_tdata", got_q.size() > 0 ? got_q[0].d : '0, 128'h000000C3_000000C2_000000C1_000000C0);
    @(posedge clk);
    #1;
    check_beats("gaps");

    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(32'h11 + i), 1'b1, 1'b0, w);
    held = 128'h00000014_00000013_00000012_00000011;
    in_data  = 32'h15;
    in_keep  = 1'b1;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_tvalid", AW'(out_tvalid), AW'(1));
      chk("stall_tdata", out_tdata, held);
      chk("stall_in_ready", AW'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    out_tready = 1'b1;
    for (int i = 4; i < 8; i++) send(DW'(32'h11 + i), 1'b1, 1'b0, w);
    check_beats("backpressure");

    send(32'hEE, 1'b0, 1'b1, w);
    send(32'h77, 1'b1, 1'b1, w);
    repeat (2) @(negedge clk);
    chk("single_k0_tkeep", got_q.size() > 0 ? AW'(got_q[0].k) : AW'(1), '0);
    chk("single_k0_tlast", got_q.size() > 0 ? AW'(got_q[0].l) : '0, AW'(1));
    chk("single_next_slot0", got_q.size() > 1 ? got_q[1].d : '0, AW'(32'h77));
    @(posedge clk);
    #1;
    check_beats("single");

    out_tready = 1'b0;
    send(32'h55, 1'b1, 1'b1, w);
    #1;
    chk("pend_tvalid", AW'(out_tvalid), AW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", AW'(out_tvalid), '0);
    chk("async_rst_tdata", out_tdata, '0);
    chk("async_rst_tkeep", AW'(out_tkeep), '0);
    exp_q.delete();
    slot_d.delete();
    slot_k.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_tready = 1'b1;
    send(32'hDEAD0001, 1'b1, 1'b0, w);
    send(32'hDEAD0002, 1'b1, 1'b0, w);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", AW'(out_tvalid), '0);
    slot_d.delete();
    slot_k.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(32'h600 + i), 1'b1, (i == 3), w);
    check_beats("post_reset");

    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 9);
      for (int e = 0; e < len; e++) send(DW'($urandom), 1'($urandom_range(0, 1)), (e == len - 1), w);
    end
    rand_ready = 1'b0;
    check_beats("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
